bin_down_cnt: RTL

//   Loadable binary down-counter / countdown timer: the counting-down

---
 rtl/bin_down_cnt_if.sv | 24 ++
 rtl/bin_down_cnt.sv | 89 ++++++++
 2 files changed

// File: rtl/bin_down_cnt_if.sv
// Control and status bundle for the loadable down-counter.
// The master drives load/start/pause; the slave (counter) reports count and state.
interface bin_down_cnt_if #(
    parameter int unsigned CNT_BIT_WIDTH = 4
) ();
    logic                     load;
    logic [CNT_BIT_WIDTH-1:0] load_val;
    logic                     start;
    logic                     pause;
    logic [CNT_BIT_WIDTH-1:0] q;
    logic                     borrow;
    logic                     busy;
    logic [1:0]               state;

    modport master (
        output load, load_val, start, pause,
        input  q, borrow, busy, state
    );

    modport slave (
        input  load, load_val, start, pause,
        output q, borrow, busy, state
    );
endinterface

// File: rtl/bin_down_cnt.sv
// Loadable binary down-counter / countdown timer with pause, one-cycle borrow pulse
// on expiry and optional auto-reload of the last loaded value.
module bin_down_cnt #(
    parameter int unsigned CNT_BIT_WIDTH = 4,
    parameter int unsigned AUTO_RELOAD   = 0
) (
    input logic           clk,
    input logic           rst_n,
    bin_down_cnt_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_BIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_BIT_WIDTH-1:0] reload_q, reload_d;
    logic                     borrow_q, borrow_d;
    logic                     cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        borrow_d = 1'b0;
        if (bus.load) begin
            cnt_d    = bus.load_val;
            reload_d = bus.load_val;
            state_d  = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = cnt_zero ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (bus.pause) begin
                        state_d = StPause;
                    end else if (!cnt_zero) begin
                        cnt_d = cnt_q - CNT_BIT_WIDTH'(1);
                    end else begin
                        // Expiry: a zero reload value cannot restart, so it terminates too.
                        borrow_d = 1'b1;
                        if ((AUTO_RELOAD != 0) && (reload_q != '0)) begin
                            cnt_d = reload_q;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StPause: begin
                    if (bus.start) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign bus.q      = cnt_q;
    assign bus.borrow = borrow_q;
    assign bus.state  = state_q;
    assign bus.busy   = (state_q == StRun) || (state_q == StPause);
endmodule
